// File: rtl/seq_det_pkg.sv
// Shared constants, width helper and configuration record for the serial pattern detector.
// cfg_t is sized by SEQ_MAX_LEN, so override MAX_LEN on the detector together with it.
package seq_det_pkg;

  localparam int unsigned SEQ_MAX_LEN = 8;

  function automatic int unsigned seq_lw(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int unsigned SEQ_LW = seq_lw(SEQ_MAX_LEN);

  localparam logic [SEQ_MAX_LEN-1:0] SEQ_DEFAULT_PATTERN = 8'b0000_0101;
  localparam logic [SEQ_LW-1:0]      SEQ_DEFAULT_LEN     = 4'd4;

  typedef struct packed {
    logic [SEQ_MAX_LEN-1:0] pattern;
    logic [SEQ_LW-1:0]      len;
    logic                   overlap;
  } cfg_t;

endpackage

// File: rtl/seq_detector_param_prefix.sv
// Combinational prefix matcher: longest pattern prefix ending in the newest bit, capped at
// min(state_eff+1, len). history_i[0] is the most recent bit before data_i.
module seq_prefix_match
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = SEQ_MAX_LEN,
  parameter int unsigned LW      = seq_lw(MAX_LEN)
) (
  input  logic [MAX_LEN-2:0] history_i,
  input  logic               data_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [LW-1:0]      len_i,
  input  logic [LW-1:0]      state_eff_i,
  output logic [LW-1:0]      next_o
);

  logic [MAX_LEN-1:0] hit_s;
  logic [LW-1:0]      next_s;
  logic               found_s;

  // Per-length match flags, gated by the allowed prefix length.
  always_comb begin : hit_calc
    logic ok_s;
    hit_s = '0;
    ok_s  = 1'b0;
    for (int k = 1; k <= int'(MAX_LEN); k++) begin
      ok_s = (pattern_i[k-1] == data_i);
      for (int j = 0; j < k - 1; j++) begin
        ok_s = ok_s & (pattern_i[j] == history_i[k-2-j]);
      end
      hit_s[k-1] = ok_s && (k <= int'(len_i)) && (k <= int'(state_eff_i) + 1);
    end
  end

  // Descending priority: the first hit from the top is the longest prefix.
  always_comb begin
    next_s  = '0;
    found_s = 1'b0;
    for (int k = int'(MAX_LEN); k >= 1; k--) begin
      next_s  = (hit_s[k-1] && !found_s) ? LW'(k) : next_s;
      found_s = found_s | hit_s[k-1];
    end
  end

  assign next_o = next_s;

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector with runtime-loadable pattern, overlap mode and a
// saturating match counter. State = number of pattern bits currently matched.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned           MAX_LEN         = SEQ_MAX_LEN,
  parameter int unsigned           CNT_W           = 8,
  parameter logic [MAX_LEN-1:0]    DEFAULT_PATTERN = SEQ_DEFAULT_PATTERN,
  parameter logic [SEQ_LW-1:0]     DEFAULT_LEN     = SEQ_DEFAULT_LEN
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        data_valid,
  input  logic                        data_in,
  input  logic                        cfg_load,
  input  logic [MAX_LEN-1:0]          cfg_pattern,
  input  logic [seq_lw(MAX_LEN)-1:0]  cfg_len,
  input  logic                        cfg_overlap,
  output logic                        detected,
  output logic [seq_lw(MAX_LEN)-1:0]  state_out,
  output logic [CNT_W-1:0]            match_count,
  output logic                        cfg_err
);

  localparam int unsigned LW = seq_lw(MAX_LEN);
  localparam int unsigned HW = MAX_LEN - 1;

  cfg_t             cfg_q, cfg_d;
  logic [LW-1:0]    state_q, state_d, state_eff_s, k_s;
  logic [HW-1:0]    hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d, det_q, det_d, cfg_ok_s;

  assign cfg_ok_s    = (cfg_len != '0) && (int'(cfg_len) <= int'(MAX_LEN));
  assign state_eff_s = ((state_q == cfg_q.len) && !cfg_q.overlap) ? '0 : state_q;

  // Only MAX_LEN-1 past bits are stored; the newest bit comes straight from data_in.
  seq_prefix_match #(
    .MAX_LEN (MAX_LEN),
    .LW      (LW)
  ) u_match (
    .history_i   (hist_q),
    .data_i      (data_in),
    .pattern_i   (cfg_q.pattern),
    .len_i       (cfg_q.len),
    .state_eff_i (state_eff_s),
    .next_o      (k_s)
  );

  // State, configuration, history, counter and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q   <= cfg_t'{pattern: DEFAULT_PATTERN, len: DEFAULT_LEN, overlap: 1'b1};
      state_q <= '0;
      hist_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      det_q   <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      state_q <= state_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      det_q   <= det_d;
    end
  end

  // Next state: cfg_load wins over data_valid; a rejected load only raises cfg_err.
  always_comb begin
    cfg_d   = cfg_q;
    state_d = state_q;
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (cfg_load) begin
      if (cfg_ok_s) begin
        cfg_d.pattern = cfg_pattern;
        cfg_d.len     = cfg_len;
        cfg_d.overlap = cfg_overlap;
        state_d       = '0;
        hist_d        = '0;
        cnt_d         = '0;
        err_d         = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (data_valid) begin
      state_d = k_s;
      hist_d  = HW'({hist_q, data_in});
      if ((k_s == cfg_q.len) && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Moore output trails the state by one edge; an accepted load clears it at once.
  always_comb begin
    if (cfg_load && cfg_ok_s) begin
      det_d = 1'b0;
    end else begin
      det_d = (state_q == cfg_q.len);
    end
  end

  assign detected    = det_q;
  assign state_out   = state_q;
  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule
